// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared definitions for the single-bus datapath controller.
//               Holds the sequencer state encodings, control-word field
//               positions, the fixed FETCH/HOLD control words and the
//               don't-care register index. Imported by the sequencer and by
//               every per-instruction decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EX0   = 2'b01,
        ST_EX1   = 2'b10,
        ST_EX2   = 2'b11
    } state_t;

    localparam int CW_W = 31;

    // Field positions inside the 31-bit control word (MSB to LSB).
    localparam int CW_PSEL_LSB  = 29;   // [30:29]
    localparam int CW_DA_LSB    = 24;   // [28:24]
    localparam int CW_SA_LSB    = 19;   // [23:19]
    localparam int CW_SB_LSB    = 14;   // [18:14]
    localparam int CW_FSEL_LSB  = 9;    // [13:9]
    localparam int CW_REGW_BIT  = 8;
    localparam int CW_RAMW_BIT  = 7;
    localparam int CW_ENMEM_BIT = 6;
    localparam int CW_ENALU_BIT = 5;
    localparam int CW_ENB_BIT   = 4;
    localparam int CW_ENPC_BIT  = 3;
    localparam int CW_BSEL_BIT  = 2;
    localparam int CW_PCSEL_BIT = 1;
    localparam int CW_SL_BIT    = 0;

    // PC select codes.
    localparam logic [1:0] PSEL_HOLD = 2'b00;
    localparam logic [1:0] PSEL_PC4  = 2'b01;

    // Register index used when a register field is unused.
    localparam logic [4:0] REG_DC = 5'd31;

    // Assemble a control word from its fields.
    function automatic logic [CW_W-1:0] pack_cw(
        input logic [1:0] psel,
        input logic [4:0] da,
        input logic [4:0] sa,
        input logic [4:0] sb,
        input logic [4:0] fsel,
        input logic       regw,
        input logic       ramw,
        input logic       en_mem,
        input logic       en_alu,
        input logic       en_b,
        input logic       en_pc,
        input logic       bsel,
        input logic       pcsel,
        input logic       sl
    );
        logic [CW_W-1:0] cw;
        cw                    = '0;
        cw[CW_PSEL_LSB +: 2]  = psel;
        cw[CW_DA_LSB   +: 5]  = da;
        cw[CW_SA_LSB   +: 5]  = sa;
        cw[CW_SB_LSB   +: 5]  = sb;
        cw[CW_FSEL_LSB +: 5]  = fsel;
        cw[CW_REGW_BIT]       = regw;
        cw[CW_RAMW_BIT]       = ramw;
        cw[CW_ENMEM_BIT]      = en_mem;
        cw[CW_ENALU_BIT]      = en_alu;
        cw[CW_ENB_BIT]        = en_b;
        cw[CW_ENPC_BIT]       = en_pc;
        cw[CW_BSEL_BIT]       = bsel;
        cw[CW_PCSEL_BIT]      = pcsel;
        cw[CW_SL_BIT]         = sl;
        return cw;
    endfunction

    // Fetch: PC <- PC+4, no register or memory writes.
    localparam logic [CW_W-1:0] FETCH_CW = pack_cw(PSEL_PC4, REG_DC, REG_DC, REG_DC,
                                                   5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                                                   1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Hold: as fetch, but the PC reloads its own value.
    localparam logic [CW_W-1:0] HOLD_CW  = pack_cw(PSEL_HOLD, REG_DC, REG_DC, REG_DC,
                                                   5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                                                   1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/retire_counter.sv
`default_nettype none
// ============================================================================
// Module      : retire_counter
// Description : CNT_W-bit up-counter of retired instructions. Increments by
//               one when i_inc is high; wraps silently from all-ones to zero.
// Ports       : clk     - clock, rising edge
//               rst_n   - asynchronous active-low clear
//               i_inc   - increment enable
//               o_count - current count
// Revision    : 1.0 - initial release
// ============================================================================
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule : retire_counter
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Central sequencer for the single-bus datapath. Owns the state
//               register and instruction register, generates the fetch/hold
//               control words in FETCH, forwards the decoder's control word,
//               K and next state in EX0..EX2, forces illegal decoder
//               transitions back to FETCH with a one-cycle seq_error pulse,
//               and counts retired instructions.
// Ports       : clock          - clock, rising edge
//               reset_n        - asynchronous active-low reset
//               mem_data       - instruction word from memory
//               mem_ready      - mem_data valid this cycle
//               halt           - stop before the next fetch
//               dec_cw         - control word from the active decoder
//               dec_next_state - next state from the active decoder
//               dec_k          - K constant from the active decoder
//               instruction    - instruction register
//               state          - current state
//               controlword    - control word to the datapath
//               K              - constant to the datapath
//               seq_error      - pulse after an illegal decoder transition
//               retired        - retired-instruction count
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [31:0]      mem_data,
    input  logic             mem_ready,
    input  logic             halt,
    input  logic [30:0]      dec_cw,
    input  logic [1:0]       dec_next_state,
    input  logic [63:0]      dec_k,
    output logic [31:0]      instruction,
    output logic [1:0]       state,
    output logic [30:0]      controlword,
    output logic [63:0]      K,
    output logic             seq_error,
    output logic [CNT_W-1:0] retired
);

    // A decoder may only advance to the immediate successor or finish.
    function automatic logic legal_next(input state_t cur, input state_t nxt);
        logic ok;
        ok = 1'b0;
        case (cur)
            ST_EX0:  ok = (nxt == ST_FETCH) || (nxt == ST_EX1);
            ST_EX1:  ok = (nxt == ST_FETCH) || (nxt == ST_EX2);
            ST_EX2:  ok = (nxt == ST_FETCH);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t        r_state;
    logic [31:0]   r_ir;
    logic          r_seq_error;

    state_t        w_next_state;
    state_t        w_dec_next;
    logic          w_load_ir;
    logic          w_illegal;
    logic          w_retire;
    logic [30:0]   w_cw;
    logic [63:0]   w_k;

    assign w_dec_next = state_t'(dec_next_state);

    // ------------------------------------------------------------------
    // State, IR and error-pulse registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_FETCH;
            r_ir        <= '0;
            r_seq_error <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_seq_error <= w_illegal;
            if (w_load_ir) begin
                r_ir <= mem_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and output mux
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_load_ir    = 1'b0;
        w_illegal    = 1'b0;
        w_retire     = 1'b0;
        w_cw         = HOLD_CW;
        w_k          = '0;

        case (r_state)
            ST_FETCH: begin
                // halt takes priority over a ready memory word.
                if (mem_ready && !halt) begin
                    w_cw         = FETCH_CW;
                    w_load_ir    = 1'b1;
                    w_next_state = ST_EX0;
                end
            end
            default: begin
                w_cw = dec_cw;
                w_k  = dec_k;
                if (legal_next(r_state, w_dec_next)) begin
                    w_next_state = w_dec_next;
                end else begin
                    w_illegal    = 1'b1;
                    w_next_state = ST_FETCH;
                end
                // Forced or not, leaving EXn for FETCH retires the instruction.
                w_retire = (w_next_state == ST_FETCH);
            end
        endcase
    end

    retire_counter #(
        .CNT_W   (CNT_W)
    ) u_retire_counter (
        .clk     (clock),
        .rst_n   (reset_n),
        .i_inc   (w_retire),
        .o_count (retired)
    );

    assign instruction = r_ir;
    assign state       = r_state;
    assign controlword = w_cw;
    assign K           = w_k;
    assign seq_error   = r_seq_error;

endmodule : control_sequencer
`default_nettype wire
